// File: rtl/adder_tree_acc.sv
// Pipelined signed adder tree (N_IN lanes + bias) with a frame accumulator stage.
// One registered tree level per cycle; in_first/in_last framing lets wide dot products span beats.

module add_sat #(
    parameter int WIDTH = 26,
    parameter int SAT   = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);
    logic [WIDTH:0] full;

    assign full = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign ovf  = full[WIDTH] ^ full[WIDTH-1];

    always_comb begin
        sum = full[WIDTH-1:0];
        if (SAT != 0 && ovf)
            sum = full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
endmodule

module tree_node #(
    parameter int WIDTH = 26,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_ovf,
    input  logic             b_ovf,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);
    logic [WIDTH-1:0] add_sum;
    logic             add_ovf;

    add_sat #(.WIDTH(WIDTH), .SAT(SAT)) u_add (.a(a), .b(b), .sum(add_sum), .ovf(add_ovf));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
            ovf <= 1'b0;
        end else begin
            sum <= add_sum;
            ovf <= a_ovf | b_ovf | add_ovf;
        end
    end
endmodule

module adder_tree_acc #(
    parameter int N_IN  = 28,
    parameter int WIDTH = 26,
    parameter int SAT   = 1
) (
    input  logic                  clk,
    input  logic                  GlobalReset,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [N_IN*WIDTH-1:0] in_vec,
    input  logic [WIDTH-1:0]      bias,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_sum,
    output logic                  out_ovf
);
    localparam int LEVELS = $clog2(N_IN + 1);
    localparam int NLEAF  = 1 << LEVELS;
    localparam int NNODE  = 2 * NLEAF - 1;

    // Heap layout: node i has children 2i+1 / 2i+2, leaves at NLEAF-1.., root at 0.
    logic [NNODE-1:0][WIDTH-1:0] node_sum;
    logic [NNODE-1:0]            node_ovf;
    logic [LEVELS:0]             vld_pipe, first_pipe, last_pipe;

    generate
        for (genvar k = 0; k < NLEAF; k++) begin : g_leaf
            if (k < N_IN) begin : g_lane
                assign node_sum[NLEAF-1+k] = in_vec[WIDTH*k +: WIDTH];
            end else if (k == N_IN) begin : g_bias
                assign node_sum[NLEAF-1+k] = in_first ? bias : '0;
            end else begin : g_pad
                assign node_sum[NLEAF-1+k] = '0;
            end
            assign node_ovf[NLEAF-1+k] = 1'b0;
        end

        for (genvar i = 0; i < NLEAF - 1; i++) begin : g_node
            tree_node #(.WIDTH(WIDTH), .SAT(SAT)) u_node (
                .clk  (clk),
                .rst  (GlobalReset),
                .a    (node_sum[2*i+1]),
                .b    (node_sum[2*i+2]),
                .a_ovf(node_ovf[2*i+1]),
                .b_ovf(node_ovf[2*i+2]),
                .sum  (node_sum[i]),
                .ovf  (node_ovf[i])
            );
        end
    endgenerate

    assign vld_pipe[0]   = in_valid;
    assign first_pipe[0] = in_first;
    assign last_pipe[0]  = in_last;

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            vld_pipe[LEVELS:1]   <= '0;
            first_pipe[LEVELS:1] <= '0;
            last_pipe[LEVELS:1]  <= '0;
        end else begin
            vld_pipe[LEVELS:1]   <= vld_pipe[LEVELS-1:0];
            first_pipe[LEVELS:1] <= first_pipe[LEVELS-1:0];
            last_pipe[LEVELS:1]  <= last_pipe[LEVELS-1:0];
        end
    end

    logic [WIDTH-1:0] acc, acc_add, acc_nxt;
    logic             acc_ovf, acc_add_ovf, acc_ovf_nxt;

    add_sat #(.WIDTH(WIDTH), .SAT(SAT)) u_acc_add (
        .a(acc), .b(node_sum[0]), .sum(acc_add), .ovf(acc_add_ovf)
    );

    // A first beat restarts the frame, silently dropping any partial sum.
    always_comb begin
        acc_nxt     = acc_add;
        acc_ovf_nxt = acc_ovf | node_ovf[0] | acc_add_ovf;
        if (first_pipe[LEVELS]) begin
            acc_nxt     = node_sum[0];
            acc_ovf_nxt = node_ovf[0];
        end
    end

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            acc       <= '0;
            acc_ovf   <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (vld_pipe[LEVELS]) begin
                acc     <= acc_nxt;
                acc_ovf <= acc_ovf_nxt;
                if (last_pipe[LEVELS]) begin
                    out_sum   <= acc_nxt;
                    out_ovf   <= acc_ovf_nxt;
                    out_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_tree_acc.sv
// Bench for adder_tree_acc: four builds (N_IN 28/1/64, SAT 1/0) driven together,
// checked every cycle against a level-by-level reference reduction and frame accumulator.

module tb_adder_tree_acc;
    localparam int    W    = 26;
    localparam longint MAXV = 33554431;
    localparam longint MINV = -33554432;
    localparam longint SPAN = 67108864;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic            vld = 1'b0, fst = 1'b0, lst = 1'b0;
    logic [W-1:0]    bias = '0;
    logic [28*W-1:0] vec_a = '0;
    logic [W-1:0]    vec_c = '0;
    logic [64*W-1:0] vec_d = '0;
    logic            ov [4];
    logic [W-1:0]    os [4];
    logic            oo [4];

    adder_tree_acc #(.N_IN(28), .WIDTH(W), .SAT(1)) u_a (
        .clk(clk), .GlobalReset(rst), .in_valid(vld), .in_first(fst), .in_last(lst),
        .in_vec(vec_a), .bias(bias), .out_valid(ov[0]), .out_sum(os[0]), .out_ovf(oo[0]));
    adder_tree_acc #(.N_IN(28), .WIDTH(W), .SAT(0)) u_b (
        .clk(clk), .GlobalReset(rst), .in_valid(vld), .in_first(fst), .in_last(lst),
        .in_vec(vec_a), .bias(bias), .out_valid(ov[1]), .out_sum(os[1]), .out_ovf(oo[1]));
    adder_tree_acc #(.N_IN(1), .WIDTH(W), .SAT(1)) u_c (
        .clk(clk), .GlobalReset(rst), .in_valid(vld), .in_first(fst), .in_last(lst),
        .in_vec(vec_c), .bias(bias), .out_valid(ov[2]), .out_sum(os[2]), .out_ovf(oo[2]));
    adder_tree_acc #(.N_IN(64), .WIDTH(W), .SAT(0)) u_d (
        .clk(clk), .GlobalReset(rst), .in_valid(vld), .in_first(fst), .in_last(lst),
        .in_vec(vec_d), .bias(bias), .out_valid(ov[3]), .out_sum(os[3]), .out_ovf(oo[3]));

    typedef struct {
        int     d;
        int     cyc;
        longint sum;
        bit     ovf;
    } exp_t;

    exp_t   q[$];
    int     checks = 0, errors = 0, cyc = 0;
    longint acc [4];
    bit     acc_o [4];
    int     nl [4]  = '{28, 28, 1, 64};
    bit     sp [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    int     lat [4] = '{6, 6, 2, 8};
    longint lanes [64];

    task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic void sadd(input longint a, input longint b, input bit sat,
                                 output longint r, output bit o);
        longint s;
        s = a + b;
        o = (s > MAXV) || (s < MINV);
        r = s;
        if (o) begin
            if (sat) r = (s > MAXV) ? MAXV : MINV;
            else     r = (s > MAXV) ? s - SPAN : s + SPAN;
        end
    endfunction

    // Pairwise reduction of the padded leaf row, one level at a time.
    function automatic void tree_ref(input int n, input bit f, input bit sat, input longint b,
                                     output longint t, output bit to);
        longint x [128];
        bit     o [128];
        longint r;
        bit     ov1, oa, ob;
        int     cnt = 1;
        while (cnt < n + 1) cnt = cnt * 2;
        for (int i = 0; i < cnt; i++) begin
            x[i] = (i < n) ? lanes[i] : ((i == n && f) ? b : 0);
            o[i] = 1'b0;
        end
        while (cnt > 1) begin
            for (int i = 0; i < cnt / 2; i++) begin
                sadd(x[2*i], x[2*i+1], sat, r, ov1);
                oa = o[2*i];
                ob = o[2*i+1];
                x[i] = r;
                o[i] = oa | ob | ov1;
            end
            cnt = cnt / 2;
        end
        t  = x[0];
        to = o[0];
    endfunction

    task automatic scoreboard();
        for (int d = 0; d < 4; d++) begin
            int hit = -1;
            foreach (q[i]) if (q[i].d == d && q[i].cyc == cyc) hit = i;
            if (hit >= 0) begin
                chk($sformatf("dut%0d valid c%0d", d, cyc), ov[d], 1);
                chk($sformatf("dut%0d sum c%0d", d, cyc), $signed(os[d]), q[hit].sum);
                chk($sformatf("dut%0d ovf c%0d", d, cyc), oo[d], q[hit].ovf);
                q.delete(hit);
            end else begin
                chk($sformatf("dut%0d idle c%0d", d, cyc), ov[d], 0);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        scoreboard();
    endtask

    task automatic beat(input bit v, input bit f, input bit l, input longint b);
        longint t, r;
        bit     to, ao;
        vld  = v;
        fst  = f;
        lst  = l;
        bias = W'(b);
        for (int k = 0; k < 28; k++) vec_a[k*W +: W] = W'(lanes[k]);
        vec_c = W'(lanes[0]);
        for (int k = 0; k < 64; k++) vec_d[k*W +: W] = W'(lanes[k]);
        if (v) begin
            for (int d = 0; d < 4; d++) begin
                tree_ref(nl[d], f, sp[d], b, t, to);
                if (f) begin
                    acc[d]   = t;
                    acc_o[d] = to;
                end else begin
                    sadd(acc[d], t, sp[d], r, ao);
                    acc[d]   = r;
                    acc_o[d] = acc_o[d] | to | ao;
                end
                if (l) q.push_back(exp_t'{d, cyc + lat[d], acc[d], acc_o[d]});
            end
        end
        step();
        vld = 1'b0;
        fst = 1'b0;
        lst = 1'b0;
    endtask

    task automatic do_reset();
        vld = 1'b0;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("dut%0d rst valid", d), ov[d], 0);
            chk($sformatf("dut%0d rst sum", d), $signed(os[d]), 0);
            chk($sformatf("dut%0d rst ovf", d), oo[d], 0);
            acc[d]   = 0;
            acc_o[d] = 1'b0;
        end
        q.delete();
        step();
        step();
        chk("rst held sum", $signed(os[0]), 0);
        rst = 1'b0;
    endtask

    function automatic longint rnd_val(input bit full);
        logic [W-1:0] r;
        r = W'($urandom);
        if (full) return longint'($signed(r));
        return longint'($urandom_range(0, 2000)) - 1000;
    endfunction

    initial begin
        longint b;
        bit     full, v, f, l;
        #2;
        do_reset();

        // single beat, lanes k+1, bias 5
        for (int k = 0; k < 64; k++) lanes[k] = k + 1;
        beat(1, 1, 1, 5);
        repeat (5) step();
        chk("t1 sum", $signed(os[0]), 411);
        chk("t1 ovf", oo[0], 0);

        // three-beat frame, bias only on the first beat
        for (int k = 0; k < 64; k++) lanes[k] = 1;
        beat(1, 1, 0, -10);
        beat(1, 0, 0, 999);
        beat(1, 0, 1, 999);
        repeat (5) step();
        chk("t2 sum", $signed(os[0]), 74);

        // saturation vs wrap
        for (int k = 0; k < 64; k++) lanes[k] = 0;
        lanes[0] = MAXV;
        lanes[1] = MAXV;
        beat(1, 1, 1, 0);
        repeat (5) step();
        chk("t3 sat sum", $signed(os[0]), MAXV);
        chk("t3 sat ovf", oo[0], 1);
        chk("t3 wrap sum", $signed(os[1]), -2);
        chk("t3 wrap ovf", oo[1], 1);

        // restart of an open frame
        for (int k = 0; k < 64; k++) lanes[k] = 100;
        beat(1, 1, 0, 9);
        for (int k = 0; k < 64; k++) lanes[k] = 1;
        beat(1, 1, 1, 0);
        repeat (5) step();
        chk("t4 sum", $signed(os[0]), 28);

        // bubbles carrying junk flags between two beats
        for (int k = 0; k < 64; k++) lanes[k] = k;
        beat(1, 1, 0, 3);
        repeat (3) beat(0, 1, 1, 777);
        for (int k = 0; k < 64; k++) lanes[k] = 2 * k;
        beat(1, 0, 1, 0);
        repeat (5) step();
        chk("t5 sum", $signed(os[0]), 1137);

        // reset with a finished frame in flight and a partial frame open
        for (int k = 0; k < 64; k++) lanes[k] = 7;
        beat(1, 1, 1, 0);
        beat(1, 1, 0, 0);
        do_reset();
        for (int k = 0; k < 64; k++) lanes[k] = 2;
        beat(1, 1, 1, 0);
        repeat (5) step();
        chk("t6 sum", $signed(os[0]), 56);

        // non-first beat with no frame opened since reset: no bias, adds onto zero
        do_reset();
        for (int k = 0; k < 64; k++) lanes[k] = 3;
        beat(1, 0, 1, 7);
        repeat (5) step();
        chk("t7 sum", $signed(os[0]), 84);

        // random: single-beat frames first, then random framing with bubbles
        for (int n = 0; n < 300; n++) begin
            full = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 64; k++) lanes[k] = rnd_val(full);
            b = rnd_val(full);
            v = ($urandom_range(0, 4) != 0);
            if (n < 150) begin
                f = 1'b1;
                l = 1'b1;
            end else begin
                f = ($urandom_range(0, 2) == 0);
                l = ($urandom_range(0, 1) == 0);
            end
            beat(v, f, l, b);
        end
        repeat (10) step();
        chk("drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
